// File: rtl/seq_ring_pkg.sv
// Shared types and encodings for the seq_ring phase sequencer.
package seq_ring_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'b00,
      SEQ_RUN  = 2'b01
   } seq_state_t;

   localparam logic DIR_FWD      = 1'b0;
   localparam logic DIR_REV      = 1'b1;
   localparam logic MODE_CONT    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/seq_ring_dwell_cnt.sv
// Per-phase dwell counter; expire is combinational (cnt == dwell), count is registered.
// Holds while enable is low; clear dominates enable.
module seq_ring_dwell_cnt #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               enable,
   input  logic [DWELL_W-1:0] dwell,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt;

   assign expire = (cnt == dwell);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= expire ? '0 : cnt + DWELL_W'(1);
      end
   end

endmodule

// File: rtl/seq_ring.sv
// One-hot phase sequencer with programmable dwell; all outputs registered, en=0 stalls in place.
// Optional one-hot integrity checker enabled by defining SEQ_RING_ONEHOT_CHK_EN.
module seq_ring
   import seq_ring_pkg::*;
#(
   parameter  int NUM_PHASES = 4,
   parameter  int DWELL_W    = 8,
   localparam int IDX_W      = $clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  dir,
   input  logic                  mode,
   input  logic [DWELL_W-1:0]    dwell,
   output logic [NUM_PHASES-1:0] phase_out,
   output logic [IDX_W-1:0]      phase_idx,
   output logic                  busy,
   output logic                  wrap,
   output logic                  err
);

   localparam logic [NUM_PHASES-1:0] PH_FIRST = {{(NUM_PHASES-1){1'b0}}, 1'b1};
   localparam logic [NUM_PHASES-1:0] PH_LAST  = {1'b1, {(NUM_PHASES-1){1'b0}}};
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_PHASES-1);

   seq_state_t            state_q, state_n;
   logic [NUM_PHASES-1:0] phase_q, phase_n;
   logic [IDX_W-1:0]      idx_q, idx_n;
   logic                  wrap_q, wrap_n;
   logic                  expire;
   logic                  boundary;
   logic                  rev;

   assign rev      = (dir == DIR_REV);
   assign boundary = rev ? (idx_q == '0) : (idx_q == IDX_LAST);

   // IDLE keeps the counter at zero so the first phase always gets a full dwell.
   seq_ring_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (stop || (state_q != SEQ_RUN)),
      .enable (en),
      .dwell  (dwell),
      .expire (expire)
   );

`ifdef SEQ_RING_ONEHOT_CHK_EN
   logic err_q, err_n;
   logic onehot_bad;
   assign onehot_bad = (phase_q == '0) || ((phase_q & (phase_q - NUM_PHASES'(1))) != '0);
   assign err        = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      phase_n = phase_q;
      idx_n   = idx_q;
      wrap_n  = 1'b0;
`ifdef SEQ_RING_ONEHOT_CHK_EN
      err_n   = 1'b0;
`endif
      if (stop) begin
         state_n = SEQ_IDLE;
         phase_n = '0;
         idx_n   = '0;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               if (start && en) begin
                  state_n = SEQ_RUN;
                  phase_n = rev ? PH_LAST : PH_FIRST;
                  idx_n   = rev ? IDX_LAST : '0;
               end
            end
            SEQ_RUN: begin
`ifdef SEQ_RING_ONEHOT_CHK_EN
               if (onehot_bad) begin
                  err_n   = 1'b1;
                  state_n = SEQ_IDLE;
                  phase_n = '0;
                  idx_n   = '0;
               end else
`endif
               if (en && expire) begin
                  if (boundary) begin
                     wrap_n = 1'b1;
                     if (mode == MODE_ONESHOT) begin
                        state_n = SEQ_IDLE;
                        phase_n = '0;
                        idx_n   = '0;
                     end else begin
                        phase_n = rev ? PH_LAST : PH_FIRST;
                        idx_n   = rev ? IDX_LAST : '0;
                     end
                  end else if (rev) begin
                     phase_n = {phase_q[0], phase_q[NUM_PHASES-1:1]};
                     idx_n   = idx_q - IDX_W'(1);
                  end else begin
                     phase_n = {phase_q[NUM_PHASES-2:0], phase_q[NUM_PHASES-1]};
                     idx_n   = idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_n = SEQ_IDLE;
               phase_n = '0;
               idx_n   = '0;
`ifdef SEQ_RING_ONEHOT_CHK_EN
               err_n   = 1'b1;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEQ_IDLE;
         phase_q <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
`ifdef SEQ_RING_ONEHOT_CHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_n;
         phase_q <= phase_n;
         idx_q   <= idx_n;
         wrap_q  <= wrap_n;
`ifdef SEQ_RING_ONEHOT_CHK_EN
         err_q   <= err_n;
`endif
      end
   end

   assign phase_out = phase_q;
   assign phase_idx = idx_q;
   assign busy      = (state_q == SEQ_RUN);
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_seq_ring.sv
// Directed bench for seq_ring: behavioural reference model feeds a scoreboard queue, checked every cycle.
module tb_seq_ring;

   localparam int NP = 4;
   localparam int DW = 8;
   localparam int IW = $clog2(NP);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          dir = 1'b0;
   logic          mode = 1'b0;
   logic [DW-1:0] dwell = '0;
   logic [NP-1:0] phase_out;
   logic [IW-1:0] phase_idx;
   logic          busy;
   logic          wrap;
   logic          err;

   seq_ring #(.NUM_PHASES(NP), .DWELL_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .start     (start),
      .stop      (stop),
      .dir       (dir),
      .mode      (mode),
      .dwell     (dwell),
      .phase_out (phase_out),
      .phase_idx (phase_idx),
      .busy      (busy),
      .wrap      (wrap),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] phase;
      logic [31:0] idx;
      logic        busy;
      logic        wrap;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   bit   m_run = 0;
   int   m_idx = 0;
   int   m_cnt = 0;
   bit   m_wrap = 0;

   logic t_en = 1'b1, t_dir = 1'b0, t_mode = 1'b0;
   int   t_dwell = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit i_rst, input bit i_start, input bit i_stop);
      bit bnd;
      m_wrap = 0;
      if (i_rst || i_stop) begin
         m_run = 0; m_idx = 0; m_cnt = 0;
      end else if (!m_run) begin
         if (i_start && t_en) begin
            m_run = 1; m_idx = t_dir ? NP - 1 : 0; m_cnt = 0;
         end
      end else if (t_en) begin
         if (m_cnt == t_dwell) begin
            m_cnt = 0;
            bnd = t_dir ? (m_idx == 0) : (m_idx == NP - 1);
            if (bnd) begin
               m_wrap = 1;
               if (t_mode) begin
                  m_run = 0; m_idx = 0;
               end else begin
                  m_idx = t_dir ? NP - 1 : 0;
               end
            end else begin
               m_idx = t_dir ? m_idx - 1 : m_idx + 1;
            end
         end else begin
            m_cnt = (m_cnt + 1) % (1 << DW);
         end
      end
   endtask

   task automatic step(input bit i_rst, input bit i_start, input bit i_stop);
      exp_t e, got;
      @(negedge clk);
      rst = i_rst; start = i_start; stop = i_stop;
      en = t_en; dir = t_dir; mode = t_mode; dwell = DW'(t_dwell);
      model(i_rst, i_start, i_stop);
      e.phase = m_run ? (32'd1 << m_idx) : 32'd0;
      e.idx   = m_run ? 32'(m_idx) : 32'd0;
      e.busy  = m_run;
      e.wrap  = m_wrap;
      e.err   = 1'b0;
      q.push_back(e);
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk("phase_out", 32'(phase_out), got.phase);
      chk("phase_idx", 32'(phase_idx), got.idx);
      chk("busy", 32'(busy), 32'(got.busy));
      chk("wrap", 32'(wrap), 32'(got.wrap));
      chk("err", 32'(err), 32'(got.err));
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   initial begin
      // reset
      step(1, 0, 0);
      step(1, 0, 0);
      chk("rst_phase", 32'(phase_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      step(0, 0, 0);

      // continuous forward, dwell 0
      t_dwell = 0; t_mode = 0; t_dir = 0; t_en = 1;
      step(0, 1, 0);
      chk("t1_first", 32'(phase_out), 32'h1);
      chk("t1_busy", 32'(busy), 32'd1);
      idle_steps(4);
      chk("t1_wrap_phase", 32'(phase_out), 32'h1);
      chk("t1_wrap", 32'(wrap), 32'd1);
      idle_steps(3);
      step(0, 0, 1);

      // continuous forward, dwell 2
      t_dwell = 2;
      step(0, 1, 0);
      idle_steps(3);
      chk("t2_idx_c4", 32'(phase_idx), 32'd1);
      idle_steps(10);
      step(0, 0, 1);

      // one-shot reverse, dwell 0
      t_dwell = 0; t_mode = 1; t_dir = 1;
      step(0, 1, 0);
      chk("t3_first", 32'(phase_out), 32'h8);
      idle_steps(3);
      chk("t3_last", 32'(phase_out), 32'h1);
      step(0, 0, 0);
      chk("t3_end_phase", 32'(phase_out), 32'h0);
      chk("t3_end_wrap", 32'(wrap), 32'd1);
      idle_steps(2);

      // en stall mid-phase, dwell 3
      t_dwell = 3; t_mode = 0; t_dir = 0;
      step(0, 1, 0);
      idle_steps(2);
      t_en = 0;
      idle_steps(5);
      t_en = 1;
      idle_steps(10);
      step(0, 0, 1);

      // stop during phase 2, start+stop in IDLE
      t_dwell = 0;
      step(0, 1, 0);
      idle_steps(2);
      step(0, 0, 1);
      chk("t5_stop_phase", 32'(phase_out), 32'd0);
      step(0, 1, 1);
      chk("t5_startstop_busy", 32'(busy), 32'd0);

      // reset mid-run
      step(0, 1, 0);
      idle_steps(3);
      step(1, 0, 0);
      chk("t6_rst_phase", 32'(phase_out), 32'd0);
      step(0, 0, 0);

      // maximum dwell, one-shot forward
      t_dwell = (1 << DW) - 1; t_mode = 1;
      step(0, 1, 0);
      idle_steps(4 * (1 << DW));
      chk("t7_done_busy", 32'(busy), 32'd0);

      // mid-run direction change
      t_dwell = 1; t_mode = 0; t_dir = 0;
      step(0, 1, 0);
      idle_steps(3);
      t_dir = 1;
      idle_steps(8);
      step(0, 0, 1);

      // start with en low is ignored
      t_en = 0;
      step(0, 1, 0);
      chk("t9_noen_busy", 32'(busy), 32'd0);
      t_en = 1;
      step(0, 0, 0);

`ifdef SEQ_RING_ONEHOT_CHK_EN
      t_dwell = 3; t_mode = 0; t_dir = 0;
      step(0, 1, 0);
      @(negedge clk);
      start = 1'b0;
      force dut.phase_q = 4'b0110;
      @(posedge clk);
      #1;
      release dut.phase_q;
      chk("chk_err", 32'(err), 32'd1);
      chk("chk_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("chk_err_clr", 32'(err), 32'd0);
      chk("chk_phase", 32'(phase_out), 32'd0);
      m_run = 0; m_idx = 0; m_cnt = 0;
      idle_steps(2);
`endif

      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_ring.md
# seq_ring

Parametrised one-hot phase sequencer; the next generation of the team's fixed 4-phase ring FSM. It steps a one-hot `phase_out` through NUM_PHASES phases, holding each phase for a programmable dwell time. It supports forward or reverse direction, continuous or one-shot mode, clock-enable stall and abort. It sits between control logic and downstream phase-gated datapaths (multiplexed drivers, staged enables).

## Interface
- NUM_PHASES, 4: number of phases; legal range ≥ 2.
- DWELL_W, 8: width of the dwell count.
- IDX_W, $clog2(NUM_PHASES): width of `phase_idx`; derived, not overridden.

- clk  in  1  single clock; all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; when low, all state and outputs are frozen (except `start`/`stop` handling, see below).
- start  in  1  begin a sequence; honoured only in IDLE with en=1.
- stop  in  1  abort to IDLE; honoured in any state regardless of en.
- dir  in  1  0 = forward (index +1), 1 = reverse (index −1).
- mode  in  1  0 = continuous, 1 = one-shot.
- dwell  in  DWELL_W  cycles per phase minus one.
- phase_out  out  NUM_PHASES  one-hot active phase; all-zero in IDLE.
- phase_idx  out  IDX_W  binary index of active phase; 0 in IDLE.
- busy  out  1  high in RUN.
- wrap  out  1  one-cycle pulse on sequence boundary.
- err  out  1  one-cycle pulse on one-hot violation (see Configuration).

## Operation
- States: IDLE, RUN.
- Reset (rst=1 at an edge, overrides everything):
  - Next cycle: state=IDLE, phase_out=0, phase_idx=0, busy=0, wrap=0, err=0.
  - The dwell counter is cleared.
- IDLE → RUN: start=1, en=1, stop=0.
  - First phase is index 0 if dir=0, NUM_PHASES−1 if dir=1.
  - Dwell counter is cleared to 0.
- RUN, en=1:
  - If cnt == dwell: advance phase per current `dir` and clear cnt.
  - Otherwise: cnt+1.
  - `dir` and `dwell` are sampled live at each comparison/advance; a mid-run change takes effect at the next advance.
  - Comparison is equality on DWELL_W bits.
- Boundary advance (forward from NUM_PHASES−1, or reverse from 0):
  - mode=0: phase wraps to 0 (forward) or NUM_PHASES−1 (reverse); wrap=1.
  - mode=1: go to IDLE; phase_out=0, busy=0; wrap=1.
- RUN, en=0: phase, cnt and outputs hold; wrap and err are 0.
- stop=1 in RUN: IDLE next cycle, phase_out=0, wrap=0.
- Simultaneous start and stop: stop wins.
- start in RUN: ignored.

## Timing
- All outputs are registered.
- Start latency: start sampled at edge k → phase_out shows the first phase after edge k.
- With en held high, each phase is visible for dwell+1 cycles.
  - dwell=0 advances every cycle.
  - dwell=2^DWELL_W−1 holds 2^DWELL_W cycles.
- wrap is high in exactly the cycle `phase_out` first shows the wrapped-to phase (mode=0), or 0 (mode=1).
- phase_idx and phase_out always change on the same edge and always agree.

## Configuration
- Macro: SEQ_RING_ONEHOT_CHK_EN.
- Defined:
  - Every cycle in RUN, the internal one-hot phase register is checked for exactly one set bit.
  - On violation: err=1 for one cycle, and next state is IDLE with phase_out=0 and busy=0.
  - Any non-IDLE/RUN state encoding also recovers to IDLE with an err pulse.
- Not defined: err is tied to 0 and no checker logic is built. The port is always present.

## Structure
- Package `seq_ring_pkg` holds:
  - state enum (SEQ_IDLE, SEQ_RUN).
  - direction constants (DIR_FWD=0, DIR_REV=1).
  - mode constants (MODE_CONT=0, MODE_ONESHOT=1).
- Sub-module `seq_ring_dwell_cnt` (DWELL_W):
  - inputs: clear, enable, dwell.
  - output: `expire` = (cnt == dwell).
- The top level holds the FSM, the one-hot rotate (both directions) and the optional checker.

## Test plan
- NUM_PHASES=4, dwell=0, mode=0, dir=0, en=1, start pulsed at edge 0:
  - phase_out = 0001, 0010, 0100, 1000, 0001 on cycles 1–5.
  - wrap=1 only on cycle 5; busy=1 from cycle 1.
- dwell=2, same setup: each phase is held 3 cycles; phase_idx = 0,0,0,1,1,1,2,…
- mode=1, dir=1, dwell=0:
  - phase_out = 1000, 0100, 0010, 0001 on cycles 1–4.
  - cycle 5: phase_out=0000, busy=0, wrap=1.
- en dropped for 5 cycles mid-phase with dwell=3:
  - phase_out and phase_idx hold.
  - The remaining dwell resumes exactly where it stopped; no wrap or err pulse.
- Abort and reset:
  - stop during phase 2 → phase_out=0 next cycle.
  - start+stop together in IDLE → stays IDLE.
  - rst mid-run → all outputs 0 next cycle.
- With SEQ_RING_ONEHOT_CHK_EN: force the phase register to 0110 in RUN → err=1 for one cycle, then IDLE with phase_out=0. Without the macro: err stays 0.
